// File: rtl/seq_det_sched.sv
// Round-robin front end that shares one serial 10110 detector among NREQ requesters.
// Each granted word is flushed MSB-first through the detector and its hits are counted.
module seq_det_sched #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int ID_W   = $clog2(NREQ),
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   det_clr,
  output logic                   det_idata,
  output logic                   det_data_en,
  input  logic                   det_seqen,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       hit_cnt
);

  // state   | meaning
  // IDLE    | sample req, pick next requester round-robin
  // CLR     | one-cycle flush of the detector
  // SHIFT   | WORD_W bits presented to the detector
  // DRAIN   | catch the hit produced by the last bit
  // DONE    | completion pulse, grant released on exit
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  acc_q;
  logic [NREQ-1:0]   gnt_q;
  logic              det_clr_q;
  logic              det_en_q;
  logic              done_q;
  logic [ID_W-1:0]   done_id_q;
  logic [CNT_W-1:0]  hit_cnt_q;

  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic              hit_inc;

  always_comb begin
    logic [ID_W-1:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    // search starts one past the last winner so every requester gets a turn
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found) state_d = S_CLR;
      S_CLR:   state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == LAST_BIT) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // a match seen while the first bit is presented belongs to the flush, not this job
  assign hit_inc = det_seqen &&
                   (((state_q == S_SHIFT) && (bit_cnt_q != '0)) || (state_q == S_DRAIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_W'(NREQ - 1);
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      acc_q     <= '0;
      gnt_q     <= '0;
      det_clr_q <= 1'b0;
      det_en_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      det_clr_q <= (state_d == S_CLR);
      det_en_q  <= (state_d == S_SHIFT);
      done_q    <= (state_d == S_DONE);
      if (hit_inc) acc_q <= acc_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            shreg_q   <= req_data[sel_idx*WORD_W +: WORD_W];
            gnt_q     <= NREQ'(1) << sel_idx;
            ptr_q     <= sel_idx;
            acc_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        S_DRAIN: begin
          done_id_q <= ptr_q;
          hit_cnt_q <= acc_q + CNT_W'(det_seqen);
        end
        S_DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign det_clr     = det_clr_q;
  assign det_idata   = shreg_q[WORD_W-1];
  assign det_data_en = det_en_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign hit_cnt     = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: detector model, job-level reference model, directed tables and random traffic.
module tb_seq_det_sched;
  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 4;

  logic                   clk;
  logic                   reset_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   det_clr, det_idata, det_data_en, det_seqen;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       hit_cnt;

  int total = 0;
  int bad   = 0;

  seq_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .det_clr(det_clr), .det_idata(det_idata), .det_data_en(det_data_en),
    .det_seqen(det_seqen), .done(done), .done_id(done_id), .hit_cnt(hit_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // external overlapping 10110 detector; inj forces spurious matches where they must be ignored
  logic [4:0] dhist;
  logic       det_q;
  logic       inj;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dhist <= '0; det_q <= 1'b0;
    end else if (det_clr) begin
      dhist <= '0; det_q <= 1'b0;
    end else if (det_data_en) begin
      dhist <= {dhist[3:0], det_idata};
      det_q <= ({dhist[3:0], det_idata} == 5'b10110);
    end else begin
      det_q <= 1'b0;
    end
  end
  assign det_seqen = det_q | inj;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int count_hits(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int i = WORD_W - 1; i >= 4; i--)
      if (w[i -: 5] == 5'b10110) n++;
    return n;
  endfunction

  // job-level model: m_t counts cycles since the sampling edge of the current job
  bit m_act;
  int m_t, m_ptr, m_id, m_hits;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_t <= 0; m_ptr <= NREQ - 1; m_id <= 0; m_hits <= 0;
    end else if (m_act) begin
      if (m_t == WORD_W + 2) m_act <= 1'b0;
      else m_t <= m_t + 1;
    end else if (req != '0) begin
      m_act  <= 1'b1;
      m_t    <= 0;
      m_ptr  <= pick(req, m_ptr);
      m_id   <= pick(req, m_ptr);
      m_hits <= count_hits(req_data[pick(req, m_ptr)*WORD_W +: WORD_W]);
    end
  end

  int h_id, h_hits;
  always @(negedge clk) begin
    if (!reset_n) begin
      h_id <= 0; h_hits <= 0;
    end else begin
      chk("mon_gnt", int'(gnt), m_act ? (1 << m_id) : 0);
      chk("mon_clr", int'(det_clr), int'(m_act && m_t == 0));
      chk("mon_den", int'(det_data_en), int'(m_act && m_t >= 1 && m_t <= WORD_W));
      chk("mon_done", int'(done), int'(m_act && m_t == WORD_W + 2));
      if (m_act && m_t == WORD_W + 2) begin
        chk("mon_done_id", int'(done_id), m_id);
        chk("mon_hit_cnt", int'(hit_cnt), m_hits);
        h_id <= m_id; h_hits <= m_hits;
      end else begin
        chk("mon_hold_id", int'(done_id), h_id);
        chk("mon_hold_hits", int'(hit_cnt), h_hits);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0]   r;
    logic [WORD_W-1:0] w;
    int                id;
    int                hits;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int n = 0, t0 = -1, td = -1, den_n = 0, gnt_bad = 0;
    @(negedge clk);
    req_data[v.id*WORD_W +: WORD_W] = v.w;
    req = v.r;
    while (td < 0 && n < 60) begin
      @(negedge clk); n++;
      if (t0 < 0 && gnt != '0) begin
        t0 = n;
        req_data[v.id*WORD_W +: WORD_W] = ~v.w;
      end
      if (t0 >= 0 && gnt != v.r) gnt_bad++;
      if (det_data_en) den_n++;
      if (done) begin
        td = n;
        chk($sformatf("vec%0d_id", k), int'(done_id), v.id);
        chk($sformatf("vec%0d_hits", k), int'(hit_cnt), v.hits);
        req = '0;
      end
    end
    chk($sformatf("vec%0d_seen_done", k), int'(td >= 0), 1);
    if (td >= 0) begin
      chk($sformatf("vec%0d_latency", k), td - t0, WORD_W + 2);
      chk($sformatf("vec%0d_den_cycles", k), den_n, WORD_W);
      chk($sformatf("vec%0d_gnt_held", k), gnt_bad, 0);
    end
    req = '0;
    @(negedge clk);
  endtask

  vec_t tbl[7];

  initial begin
    int ids[5], tds[5];
    int nd, n, clr_n, dn;
    reset_n = 1'b0; req = '0; req_data = '0; inj = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_clr", int'(det_clr), 0);
    chk("rst_idata", int'(det_idata), 0);
    chk("rst_den", int'(det_data_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    #2 reset_n = 1'b1;

    tbl[0] = '{4'b0001, 8'b10110000, 0, 1};
    tbl[1] = '{4'b0010, 8'b10110110, 1, 2};
    tbl[2] = '{4'b1000, 8'b11110110, 3, 1};
    tbl[3] = '{4'b0100, 8'b00101100, 2, 1};
    tbl[4] = '{4'b0001, 8'hFF,       0, 0};
    tbl[5] = '{4'b0100, 8'b10110101, 2, 1};
    tbl[6] = '{4'b1000, 8'b01011011, 3, 1};
    for (int k = 0; k < 7; k++) run_vec(tbl[k], k);

    // fairness: all requesters held, requester 0 first after reset
    do_reset();
    @(negedge clk);
    req_data = '1; req = 4'b1111;
    nd = 0; n = 0;
    while (nd < 5 && n < 100) begin
      @(negedge clk); n++;
      if (done) begin
        ids[nd] = int'(done_id); tds[nd] = n;
        chk($sformatf("fair_hits%0d", nd), int'(hit_cnt), 0);
        nd++;
      end
    end
    req = '0;
    chk("fair_jobs", nd, 5);
    for (int k = 0; k < nd; k++) chk($sformatf("fair_id%0d", k), ids[k], k % NREQ);
    for (int k = 1; k < nd; k++) chk($sformatf("fair_period%0d", k), tds[k] - tds[k-1], WORD_W + 4);
    repeat (2) @(negedge clk);

    // isolation: 1011 at the tail of job 0 followed by a leading 0 in job 1
    do_reset();
    @(negedge clk);
    req_data = '0;
    req_data[0 +: WORD_W]      = 8'b00001011;
    req_data[WORD_W +: WORD_W] = 8'b01111111;
    req = 4'b0011;
    nd = 0; n = 0; clr_n = 0;
    while (nd < 2 && n < 80) begin
      @(negedge clk); n++;
      if (det_clr) clr_n++;
      if (done) begin
        chk($sformatf("iso_id%0d", nd), int'(done_id), nd);
        chk($sformatf("iso_hits%0d", nd), int'(hit_cnt), 0);
        req[done_id] = 1'b0;
        nd++;
      end
    end
    req = '0;
    chk("iso_jobs", nd, 2);
    chk("iso_clr_pulses", clr_n, 2);
    repeat (2) @(negedge clk);

    // reset in the middle of a shift: job is aborted silently, pointer restarts at 0
    @(negedge clk);
    req_data[2*WORD_W +: WORD_W] = 8'b10110110;
    req = 4'b0100;
    n = 0; dn = 0;
    while (dn < 4 && n < 30) begin
      @(negedge clk); n++;
      if (det_data_en) dn++;
    end
    chk("rstmid_reached_bit4", dn, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_gnt", int'(gnt), 0);
    chk("rstmid_den", int'(det_data_en), 0);
    chk("rstmid_done", int'(done), 0);
    req_data[0 +: WORD_W] = 8'b10110000;
    req = 4'b0101;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rstmid_no_done", nd, 0);
    #2 reset_n = 1'b1;
    n = 0;
    while (gnt == '0 && n < 10) begin @(negedge clk); n++; end
    chk("rstmid_first_gnt", int'(gnt), 1);
    n = 0;
    while (req != '0 && n < 60) begin
      @(negedge clk); n++;
      if (done) req[done_id] = 1'b0;
    end
    chk("rstmid_served", int'(req), 0);
    req = '0;
    repeat (2) @(negedge clk);

    // random traffic against the model, with spurious matches where they must be ignored
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && done && int'(done_id) == i) req[i] = 1'b0;
        else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(7) == 0) begin
          req[i] = 1'b1;
          req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        end
        if ($urandom_range(31) == 0) req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
      end
      inj = (!m_act || m_t <= 1 || m_t == WORD_W + 2) && ($urandom_range(3) == 0);
    end
    @(negedge clk);
    inj = 1'b0; req = '0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
